// File: rtl/arashi_pkg.sv
// Shared types for the arashi read scheduler: default thread-id width and scheduler states.
package arashi_pkg;

  localparam int unsigned THREAD_NUM_WIDTH = 2;

  typedef logic [THREAD_NUM_WIDTH-1:0] thread_id_t;

  typedef enum logic {
    IDLE,
    BURST
  } sched_state_e;

endpackage

// File: rtl/arashi_rr_pick.sv
// Round-robin picker: first requesting thread strictly after ptr, wrapping, so ptr itself comes last.
module arashi_rr_pick #(
  parameter int unsigned THREAD_NUM_WIDTH = 2
) (
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0] req,
  input  logic [THREAD_NUM_WIDTH-1:0]      ptr,
  output logic                             found,
  output logic [THREAD_NUM_WIDTH-1:0]      id
);

  localparam int unsigned THREAD_NUM = 1 << THREAD_NUM_WIDTH;

  logic [2*THREAD_NUM-1:0]     dbl;
  logic [2*THREAD_NUM-1:0]     shifted;
  logic [THREAD_NUM_WIDTH:0]   sh;
  logic [THREAD_NUM-1:0]       rot;
  logic [THREAD_NUM_WIDTH-1:0] off;

  // Rotate so that bit 0 is the thread just after ptr, priority-encode, then un-rotate by adding back.
  assign dbl     = {req, req};
  assign sh      = (THREAD_NUM_WIDTH+1)'(ptr) + (THREAD_NUM_WIDTH+1)'(1);
  assign shifted = dbl >> sh;
  assign rot     = shifted[THREAD_NUM-1:0];
  assign found   = |req;

  always_comb begin
    off = '0;
    for (int unsigned i = THREAD_NUM; i > 0; i--) begin
      if (rot[i-1]) off = THREAD_NUM_WIDTH'(i-1);
    end
  end

  assign id = ptr + off + THREAD_NUM_WIDTH'(1);

endmodule

// File: rtl/arashi_rd_sched.sv
// Round-robin burst read scheduler for the shared thread memory, with write-side occupancy tracking.
module arashi_rd_sched
  import arashi_pkg::*;
#(
  parameter int unsigned THREAD_NUM_WIDTH = 2,
  parameter int unsigned MEM_WIDTH        = 4,
  parameter int unsigned BURST_MAX        = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0] req,
  input  logic                             wr_en,
  output logic                             rd_en,
  output logic [THREAD_NUM_WIDTH-1:0]      rd_thread_id,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0] gnt,
  output logic                             data_vld,
  output logic [THREAD_NUM_WIDTH-1:0]      vld_thread_id,
  output logic [MEM_WIDTH:0]               count,
  output logic                             empty,
  output logic                             full,
  output logic                             wr_drop
);

  localparam int unsigned THREAD_NUM = 1 << THREAD_NUM_WIDTH;
  localparam int unsigned DEPTH      = 1 << MEM_WIDTH;
  localparam int unsigned BCW        = $clog2(BURST_MAX + 1);

  sched_state_e                state, state_nxt;
  logic [THREAD_NUM_WIDTH-1:0] owner, sel;
  logic [THREAD_NUM_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [BCW-1:0]              burst_cnt, burst_cnt_nxt;
  logic [MEM_WIDTH:0]          count_nxt;

  logic [THREAD_NUM_WIDTH-1:0] pick_ptr, pick_id;
  logic                        pick_found;
  logic                        has_data, is_full, cont, sched, wr_acc;

  assign has_data = (count != '0);
  assign is_full  = (count == (MEM_WIDTH+1)'(DEPTH));
  assign empty    = ~has_data;
  assign full     = is_full;

  // One picker serves both cases: from IDLE it searches after rr_ptr, at burst end after the
  // outgoing owner, which is exactly the value rr_ptr takes on that edge.
  assign pick_ptr = (state == IDLE) ? rr_ptr : owner;

  arashi_rr_pick #(
    .THREAD_NUM_WIDTH(THREAD_NUM_WIDTH)
  ) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .found(pick_found),
    .id   (pick_id)
  );

  assign cont = (state == BURST) && req[owner] && has_data &&
                (burst_cnt < BCW'(BURST_MAX));

  always_comb begin
    sched         = 1'b0;
    sel           = owner;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    rr_ptr_nxt    = rr_ptr;
    if (state == IDLE) begin
      if (pick_found && has_data) begin
        sched         = 1'b1;
        sel           = pick_id;
        burst_cnt_nxt = BCW'(1);
        state_nxt     = BURST;
      end
    end else if (cont) begin
      sched         = 1'b1;
      burst_cnt_nxt = burst_cnt + BCW'(1);
    end else begin
      rr_ptr_nxt = owner;
      if (pick_found && has_data) begin
        sched         = 1'b1;
        sel           = pick_id;
        burst_cnt_nxt = BCW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // A scheduled read frees a slot on the same edge, so a write to a full memory still lands.
  assign wr_acc = wr_en & (~is_full | sched);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, sched})
      2'b10:   count_nxt = count + (MEM_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (MEM_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      owner         <= '0;
      burst_cnt     <= '0;
      rr_ptr        <= '1;
      count         <= '0;
      rd_en         <= 1'b0;
      rd_thread_id  <= '0;
      gnt           <= '0;
      data_vld      <= 1'b0;
      vld_thread_id <= '0;
      wr_drop       <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= sel;
      burst_cnt     <= burst_cnt_nxt;
      rr_ptr        <= rr_ptr_nxt;
      count         <= count_nxt;
      rd_en         <= sched;
      if (sched) rd_thread_id <= sel;
      gnt           <= sched ? (THREAD_NUM'(1) << sel) : '0;
      data_vld      <= rd_en;
      vld_thread_id <= rd_thread_id;
      wr_drop       <= wr_en & ~wr_acc;
    end
  end

endmodule
